// File: rtl/keypad_encoder.sv
// -----------------------------------------------------------------------------
// keypad_encoder
// Front-panel input stage for the microwave timer. Raw keypad lines are
// synchronized, debounced and encoded. Each accepted digit produces one
// active-low load strobe that shifts its BCD code into the timer. START and
// STOP produce one-cycle strobes for the control FSM. While the oven is
// running (lock high) digit and START presses are swallowed; STOP always passes.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   clear      in   1   synchronous active-high reset
//   keys       in  12   raw key lines, active-high (0-9 digits, 10 START, 11 STOP)
//   lock       in   1   timer running; blocks digit and START acceptance
//   bcd_output out  4   BCD code of the last accepted digit
//   loadn      out  1   active-low one-cycle load strobe
//   start_p    out  1   one-cycle START strobe
//   stop_p     out  1   one-cycle STOP strobe
//   busy       out  1   high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module keypad_encoder #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [11:0] keys,
    input  logic        lock,
    output logic [3:0]  bcd_output,
    output logic        loadn,
    output logic        start_p,
    output logic        stop_p,
    output logic        busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_ZERO = CW'(0);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // True when exactly one key line is active.
    function automatic logic f_onehot(input logic [11:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 12; i++) begin
            n = n + {3'b000, v[i]};
        end
        return (n == 4'd1);
    endfunction

    // Index of the active key; only meaningful when the vector is one-hot.
    function automatic logic [3:0] f_index(input logic [11:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    logic [11:0]   r_s1;
    logic [11:0]   r_s2;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_code;
    logic [3:0]    r_bcd;
    logic          r_loadn;
    logic          r_start;
    logic          r_stop;
    logic          r_busy;

    logic          w_valid;
    logic [3:0]    w_index;
    logic          w_same;
    logic          w_none;

    assign w_valid = f_onehot(r_s2);
    assign w_index = f_index(r_s2);
    // The debounced key must remain exactly the latched single key.
    assign w_same  = (r_s2 == (12'd1 << r_code));
    assign w_none  = (r_s2 == 12'd0);

    // Synchronizer, debounce FSM and registered strobe outputs.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_s1    <= 12'd0;
            r_s2    <= 12'd0;
            r_state <= ST_IDLE;
            r_cnt   <= C_ZERO;
            r_code  <= 4'd0;
            r_bcd   <= 4'd0;
            r_loadn <= 1'b1;
            r_start <= 1'b0;
            r_stop  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_s1    <= keys;
            r_s2    <= r_s1;
            // Strobes are single-cycle: default to inactive every cycle.
            r_loadn <= 1'b1;
            r_start <= 1'b0;
            r_stop  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_state <= ST_DEBOUNCE;
                        r_code  <= w_index;
                        r_cnt   <= C_ONE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_cnt   <= C_ZERO;
                        r_busy  <= 1'b0;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!w_same) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= C_ZERO;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == C_LAST) begin
                        r_state <= ST_HELD;
                        // lock is only consulted here, on entry to HELD.
                        if (r_code <= 4'd9) begin
                            if (!lock) begin
                                r_bcd   <= r_code;
                                r_loadn <= 1'b0;
                            end else begin
                                r_bcd   <= r_bcd;
                            end
                        end else if (r_code == 4'd10) begin
                            r_start <= ~lock;
                        end else begin
                            r_stop  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                ST_HELD: begin
                    // No auto-repeat; extra keys are ignored until full release.
                    if (w_none) begin
                        r_state <= ST_RELEASE;
                        r_cnt   <= C_ONE;
                    end else begin
                        r_state <= ST_HELD;
                    end
                end
                ST_RELEASE: begin
                    if (!w_none) begin
                        r_cnt <= C_ONE;
                    end else if (r_cnt == C_LAST) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= C_ZERO;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= C_ZERO;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bcd_output = r_bcd;
    assign loadn      = r_loadn;
    assign start_p    = r_start;
    assign stop_p     = r_stop;
    assign busy       = r_busy;

endmodule

// File: doc/keypad_encoder.md
Name: keypad_encoder

Overview:
- Front-panel input stage that sits directly upstream of the countdown timer.
- Synchronizes and debounces the raw microwave keypad (digits 0-9, START, STOP), encodes each accepted digit to BCD, and issues a single active-low load strobe per keypress. That strobe shifts the digit into the timer's least-significant position.
- Also produces single-cycle START/STOP strobes for the control FSM.
- Suppresses digit and START entry while the oven is running.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive synchronized cycles a key state must be stable before it is accepted. Legal minimum 2. Counter width is clog2(DEBOUNCE_CYCLES)+1.

Ports:
- clk  input  1  system clock; all logic on rising edge
- clear  input  1  synchronous, active-high reset
- keys  input  12  raw asynchronous key lines, active-high; bits 0-9 = digits 0-9, bit 10 = START, bit 11 = STOP
- lock  input  1  high while the timer is counting; blocks digit and START acceptance
- bcd_output  output  4  BCD code of the last accepted digit; held until the next accepted digit
- loadn  output  1  active-low, one-cycle load strobe to the timer
- start_p  output  1  one-cycle active-high START strobe
- stop_p  output  1  one-cycle active-high STOP strobe
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (clear=1 at a rising edge):
  - sync flops s1/s2 = 0, state = IDLE, counter = 0, latched code = 0.
  - bcd_output = 0, loadn = 1, start_p = 0, stop_p = 0, busy = 0.
  - clear overrides every other input.
  - A reset mid-debounce or mid-hold discards the press; no strobe is emitted.
- Synchronizer: two-flop chain keys -> s1 -> s2. The FSM looks only at s2.
- Valid press: exactly one bit of s2 is set. Zero bits or two or more bits is "no valid key".
- FSM states:
  - IDLE:
    - valid press -> DEBOUNCE; latch key index; counter = 1.
    - otherwise stay.
  - DEBOUNCE:
    - s2 still shows the same single key and counter < DEBOUNCE_CYCLES-1 -> counter++.
    - same key and counter == DEBOUNCE_CYCLES-1 -> HELD; emit the strobe for this key (registered).
    - any other s2 value -> IDLE, counter = 0, no strobe.
  - HELD:
    - s2 == 0 -> RELEASE, counter = 1.
    - otherwise stay. No auto-repeat; an added second key is ignored.
  - RELEASE:
    - s2 == 0 and counter == DEBOUNCE_CYCLES-1 -> IDLE.
    - s2 == 0 -> counter++.
    - s2 != 0 -> counter = 1, stay in RELEASE.
- Strobe emission (the HELD entry edge):
  - Digit d, lock=0: bcd_output <= d; loadn low for exactly one cycle. bcd_output is already valid in that cycle and stays stable afterwards.
  - Digit, lock=1: no loadn; bcd_output unchanged.
  - START, lock=0: start_p high one cycle. With lock=1: dropped.
  - STOP: stop_p high one cycle regardless of lock.
  - At most one of {loadn low, start_p, stop_p} is active in any cycle.
- lock is sampled on the HELD entry edge only. lock changing during DEBOUNCE has no other effect.
- Latency: take edge 1 as the first edge where s1 captures the key high. The strobe is high in the cycle after edge DEBOUNCE_CYCLES+2. Exactly one strobe per press.
- Minimum re-press interval: the key must have been seen released (s2 == 0) for DEBOUNCE_CYCLES cycles before the next press is accepted.
- busy = (state != IDLE).

Test Plan:
1. DEBOUNCE_CYCLES=4, clear, then keys=0x008 (digit 3) held 20 cycles, then released -> loadn low exactly one cycle, after edge 6. bcd_output=3 in that cycle and afterwards. start_p = stop_p = 0.
2. Digit 7 bouncing 1,0,1,0 on alternate cycles, then stable 10 cycles -> exactly one loadn pulse with bcd_output=7, 6 edges after the stable run begins. No pulse during the bounce.
3. keys=0x003 (digits 0 and 1 together) for 20 cycles -> no strobes, state stays IDLE, bcd_output unchanged.
4. lock=1; press digit 5, then START, then STOP (each held 10 and released 10 cycles) -> no loadn, no start_p, one stop_p pulse. bcd_output keeps its prior value.
5. Press digits 1, 2, 0 in sequence (hold 10, release 10 each) -> three loadn pulses with bcd_output 1, 2, 0 respectively. Releases shorter than 4 cycles between presses yield no extra pulses.
6. Hold digit 9 until the FSM reaches DEBOUNCE with counter=2, pulse clear for one cycle, keep the key held -> all outputs at reset values after the clear edge. The FSM re-debounces from IDLE and emits one loadn with bcd_output=9, 6 edges after the edge where clear drops.
